regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/regfile_write_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the register-file write arbiter: default widths,
// the arbiter FSM state type and the encoding of the last-served pointer.
package regfile_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_REGS_DEF = 32;

  // The arbiter clears the register file first, then serves requests.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Last-served pointer values (which requester took the last transfer).
  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin grant decision, purely combinational.
// Ports:
//   req[1:0] : request vector, bit 0 = requester A, bit 1 = requester B
//   last     : requester that took the last transfer (LAST_A / LAST_B)
//   gnt[1:0] : one-hot grant (or zero when nobody requests)
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == LAST_B) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Arbitrates the register-file write port between the ALU writeback (A) and
// the load unit (B). After reset it first sweeps zeros into every register,
// then grants one writer per cycle with round-robin tie breaking. The winning
// write is registered, so the register file sees it one cycle after transfer.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data  : requester A handshake and payload
//   b_valid/b_ready/b_addr/b_data  : requester B handshake and payload
//   rf_wen/rf_waddr/rf_wdata       : registered register-file write port
//   init_done                      : zero sweep finished, requests served
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                rf_wen_q, rf_wen_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                init_done_q, init_done_d;
  logic [1:0]          gnt;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;

  rr_arbiter2 u_rr (
    .req  ({b_valid, a_valid}),
    .last (last_q),
    .gnt  (gnt)
  );

  // Grants are only exposed once the sweep is over.
  assign a_ready = (state_q == RUN) && gnt[0];
  assign b_ready = (state_q == RUN) && gnt[1];

  // Payload of whichever requester holds the grant.
  always_comb begin
    win_addr = a_addr;
    win_data = a_data;
    if (gnt[1]) begin
      win_addr = b_addr;
      win_data = b_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    rf_wen_d    = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    init_done_d = init_done_q;

    case (state_q)
      INIT: begin
        rf_wen_d   = 1'b1;
        rf_waddr_d = cnt_q;
        rf_wdata_d = '0;
        // The write of the last index is also the edge that enters RUN.
        if (cnt_q == LAST_IDX) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (a_ready || b_ready) begin
          // Register 0 is hard-wired zero: accept the write but drop it.
          rf_wen_d   = (win_addr != '0);
          rf_waddr_d = win_addr;
          rf_wdata_d = win_data;
          last_d     = b_ready ? LAST_B : LAST_A;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Last-served resets to B so that A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      last_q      <= LAST_B;
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      rf_wen_q    <= rf_wen_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Self-checking bench: directed scenarios plus random traffic, compared
// against a behavioural model of the arbiter and of the register file.
module tb_regfile_write_arbiter;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              a_valid = 1'b0, b_valid = 1'b0;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] a_data = '0, b_data = '0;
  logic              rf_wen, init_done;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  int n_vec  = 0;
  int n_miss = 0;

  regfile_write_arbiter #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  // Register file driven by the DUT write port.
  logic [DATA_W-1:0] rf_mem [NUM_REGS];
  always @(posedge clk) begin
    if (rf_wen) rf_mem[rf_waddr] <= rf_wdata;
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_regs [NUM_REGS];
  bit                m_init;
  int                m_cnt;
  bit                m_last_b;
  bit                exp_wen, exp_done;
  logic [ADDR_W-1:0] exp_waddr;
  logic [DATA_W-1:0] exp_wdata;
  bit                exp_a_ready, exp_b_ready;
  logic              obs_a_ready, obs_b_ready;
  int                last_win;

  // Requester obligation: a stalled requester keeps its payload stable.
  logic              hold_a = 1'b0, hold_b = 1'b0;
  logic [ADDR_W-1:0] ha_addr, hb_addr;
  logic [DATA_W-1:0] ha_data, hb_data;
  always @(posedge clk) begin
    if (hold_a && a_valid && (a_addr !== ha_addr || a_data !== ha_data))
      $error("[TB] requester A changed payload while stalled");
    if (hold_b && b_valid && (b_addr !== hb_addr || b_data !== hb_data))
      $error("[TB] requester B changed payload while stalled");
    hold_a  <= rst_n && init_done && a_valid && !a_ready;
    hold_b  <= rst_n && init_done && b_valid && !b_ready;
    ha_addr <= a_addr; ha_data <= a_data;
    hb_addr <= b_addr; hb_data <= b_data;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // 0 = nobody, 1 = A, 2 = B; on a tie the requester not served last wins.
  function automatic int pick(input bit av, input bit bv, input bit lb);
    if (av && bv) return lb ? 1 : 2;
    if (av) return 1;
    if (bv) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_init    = 1'b1;
    m_cnt     = 0;
    m_last_b  = 1'b1;
    exp_wen   = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
    exp_done  = 1'b0;
  endtask

  // One clock cycle: drive at negedge, sample readies, step the model at the
  // rising edge, and return 1 time unit after that edge.
  task automatic drive_cycle(input bit av, input logic [ADDR_W-1:0] aa,
                             input logic [DATA_W-1:0] ad, input bit bv,
                             input logic [ADDR_W-1:0] ba,
                             input logic [DATA_W-1:0] bd);
    int win;
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    obs_a_ready = a_ready;
    obs_b_ready = b_ready;
    win = m_init ? 0 : pick(av, bv, m_last_b);
    exp_a_ready = (win == 1);
    exp_b_ready = (win == 2);
    last_win    = win;
    @(posedge clk);
    if (exp_wen) ref_regs[exp_waddr] = exp_wdata;
    if (m_init) begin
      exp_wen   = 1'b1;
      exp_waddr = ADDR_W'(m_cnt);
      exp_wdata = '0;
      if (m_cnt == NUM_REGS - 1) begin
        m_init   = 1'b0;
        exp_done = 1'b1;
      end else begin
        m_cnt++;
      end
    end else if (win != 0) begin
      exp_waddr = (win == 1) ? aa : ba;
      exp_wdata = (win == 1) ? ad : bd;
      exp_wen   = (exp_waddr != 0);
      m_last_b  = (win == 2);
    end else begin
      exp_wen = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 64'h1;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 64'h2;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({rf_wen, rf_waddr, rf_wdata, init_done} !== '0) begin
      n_miss++;
      $display("[TB] FAIL reset_outputs: got wen=%b addr=%0d data=%h done=%b, want all 0",
               rf_wen, rf_waddr, rf_wdata, init_done);
    end
    n_vec++;
    if ({a_ready, b_ready} !== 2'b00) begin
      n_miss++;
      $display("[TB] FAIL reset_ready: got a=%b b=%b, want 0 0", a_ready, b_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_init_sweep(input bit with_req);
    for (int i = 0; i < NUM_REGS; i++) begin
      drive_cycle(with_req, 5'd9, 64'h99, with_req, 5'd10, 64'h1010);
      n_vec++;
      if ({obs_a_ready, obs_b_ready} !== 2'b00) begin
        n_miss++;
        $display("[TB] FAIL sweep_ready[%0d]: got a=%b b=%b, want 0 0",
                 i, obs_a_ready, obs_b_ready);
      end
      n_vec++;
      if ({rf_wen, rf_waddr, rf_wdata, init_done} !==
          {1'b1, ADDR_W'(i), {DATA_W{1'b0}}, (i == NUM_REGS - 1)}) begin
        n_miss++;
        $display("[TB] FAIL sweep_write[%0d]: got wen=%b addr=%0d data=%h done=%b, want 1 %0d 0 %b",
                 i, rf_wen, rf_waddr, rf_wdata, init_done, i, (i == NUM_REGS - 1));
      end
    end
  endtask

  task automatic test_init_idle();
    drive_cycle(0, '0, '0, 0, '0, '0);
    n_vec++;
    if ({rf_wen, init_done} !== 2'b01) begin
      n_miss++;
      $display("[TB] FAIL init_idle: got wen=%b done=%b, want 0 1", rf_wen, init_done);
    end
    for (int j = 0; j < NUM_REGS; j++) begin
      n_vec++;
      if (rf_mem[j] !== '0) begin
        n_miss++;
        $display("[TB] FAIL init_clear[%0d]: got %h, want 0", j, rf_mem[j]);
      end
    end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive_cycle(1, 5'd3, {16{4'hA}}, 1, 5'd4, {16{4'hB}});
      else       drive_cycle(0, '0, '0, 0, '0, '0);
      n_vec++;
      if (k < 4 && {obs_b_ready, obs_a_ready} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_miss++;
        $display("[TB] FAIL rr_grant[%0d]: got a=%b b=%b, want %s",
                 k, obs_a_ready, obs_b_ready, (k % 2 == 0) ? "A" : "B");
      end
      n_vec++;
      if ({rf_wen, rf_waddr, rf_wdata} !== {exp_wen, exp_waddr, exp_wdata}) begin
        n_miss++;
        $display("[TB] FAIL rr_write[%0d]: got wen=%b addr=%0d data=%h, want %b %0d %h",
                 k, rf_wen, rf_waddr, rf_wdata, exp_wen, exp_waddr, exp_wdata);
      end
    end
  endtask

  task automatic test_same_addr();
    repeat (3) drive_cycle(0, '0, '0, 0, '0, '0);
    drive_cycle(1, 5'd5, 64'h11, 1, 5'd5, 64'h22);
    n_vec++;
    if ({obs_a_ready, obs_b_ready} !== 2'b10) begin
      n_miss++;
      $display("[TB] FAIL same_addr_first: got a=%b b=%b, want 1 0", obs_a_ready, obs_b_ready);
    end
    drive_cycle(0, '0, '0, 1, 5'd5, 64'h22);
    n_vec++;
    if ({obs_a_ready, obs_b_ready} !== 2'b01) begin
      n_miss++;
      $display("[TB] FAIL same_addr_second: got a=%b b=%b, want 0 1", obs_a_ready, obs_b_ready);
    end
    repeat (2) drive_cycle(0, '0, '0, 0, '0, '0);
    n_vec++;
    if (rf_mem[5] !== 64'h22) begin
      n_miss++;
      $display("[TB] FAIL same_addr_final: got reg5=%h, want 22", rf_mem[5]);
    end
  endtask

  task automatic test_only_b();
    for (int d = 1; d <= 5; d++) begin
      if (d <= 3) drive_cycle(0, '0, '0, 1, 5'd7, DATA_W'(d));
      else        drive_cycle(0, '0, '0, 0, '0, '0);
      n_vec++;
      if ({obs_a_ready, obs_b_ready} !== {1'b0, (d <= 3)}) begin
        n_miss++;
        $display("[TB] FAIL only_b_ready[%0d]: got a=%b b=%b, want 0 %b",
                 d, obs_a_ready, obs_b_ready, (d <= 3));
      end
      n_vec++;
      if ({rf_wen, rf_wdata} !== {(d <= 3), DATA_W'(d <= 3 ? d : 3)}) begin
        n_miss++;
        $display("[TB] FAIL only_b_write[%0d]: got wen=%b data=%h, want %b %0d",
                 d, rf_wen, rf_wdata, (d <= 3), (d <= 3 ? d : 3));
      end
    end
  endtask

  task automatic test_addr_zero();
    drive_cycle(1, 5'd0, {DATA_W{1'b1}}, 0, '0, '0);
    n_vec++;
    if (obs_a_ready !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL addr0_ready: got a=%b, want 1", obs_a_ready);
    end
    n_vec++;
    if (rf_wen !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL addr0_wen: got wen=%b, want 0", rf_wen);
    end
    drive_cycle(0, '0, '0, 0, '0, '0);
    n_vec++;
    if (rf_mem[0] !== '0) begin
      n_miss++;
      $display("[TB] FAIL addr0_reg: got reg0=%h, want 0", rf_mem[0]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) drive_cycle(0, '0, '0, 0, '0, '0);
    n_vec++;
    if ({rf_wen, rf_waddr} !== {1'b1, 5'd9}) begin
      n_miss++;
      $display("[TB] FAIL mid_sweep_pos: got wen=%b addr=%0d, want 1 9", rf_wen, rf_waddr);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({rf_wen, rf_waddr, rf_wdata, init_done, a_ready, b_ready} !== '0) begin
      n_miss++;
      $display("[TB] FAIL mid_sweep_abort: got wen=%b addr=%0d data=%h done=%b, want all 0",
               rf_wen, rf_waddr, rf_wdata, init_done);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    test_init_sweep(1);
  endtask

  task automatic test_random();
    bit                pa_v = 0, pb_v = 0;
    logic [ADDR_W-1:0] pa_a = '0, pb_a = '0;
    logic [DATA_W-1:0] pa_d = '0, pb_d = '0;
    for (int c = 0; c < 300; c++) begin
      if (!pa_v && $urandom_range(0, 2) != 0) begin
        pa_v = 1; pa_a = ADDR_W'($urandom_range(0, 7)); pa_d = {$urandom, $urandom};
      end
      if (!pb_v && $urandom_range(0, 2) != 0) begin
        pb_v = 1; pb_a = ADDR_W'($urandom_range(0, 7)); pb_d = {$urandom, $urandom};
      end
      drive_cycle(pa_v, pa_a, pa_d, pb_v, pb_a, pb_d);
      if (last_win == 1) pa_v = 0;
      if (last_win == 2) pb_v = 0;
      n_vec++;
      if ({obs_a_ready, obs_b_ready} !== {exp_a_ready, exp_b_ready}) begin
        n_miss++;
        $display("[TB] FAIL rand_ready[%0d]: got a=%b b=%b, want %b %b",
                 c, obs_a_ready, obs_b_ready, exp_a_ready, exp_b_ready);
      end
      n_vec++;
      if ({rf_wen, rf_waddr, rf_wdata} !== {exp_wen, exp_waddr, exp_wdata}) begin
        n_miss++;
        $display("[TB] FAIL rand_write[%0d]: got wen=%b addr=%0d data=%h, want %b %0d %h",
                 c, rf_wen, rf_waddr, rf_wdata, exp_wen, exp_waddr, exp_wdata);
      end
    end
    repeat (2) drive_cycle(0, '0, '0, 0, '0, '0);
    for (int j = 0; j < NUM_REGS; j++) begin
      n_vec++;
      if (rf_mem[j] !== ref_regs[j]) begin
        n_miss++;
        $display("[TB] FAIL rand_reg[%0d]: got %h, want %h", j, rf_mem[j], ref_regs[j]);
      end
    end
    // Reset in RUN with requests pending: everything drops at once.
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd12; b_valid = 1'b1; b_addr = 5'd13;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({rf_wen, rf_waddr, rf_wdata, init_done, a_ready, b_ready} !== '0) begin
      n_miss++;
      $display("[TB] FAIL run_reset: got wen=%b addr=%0d data=%h done=%b a=%b b=%b, want all 0",
               rf_wen, rf_waddr, rf_wdata, init_done, a_ready, b_ready);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    test_init_sweep(0);
  endtask

  initial begin
    for (int j = 0; j < NUM_REGS; j++) begin
      rf_mem[j]   = 64'hDEAD_BEEF_0000_0000 | DATA_W'(j);
      ref_regs[j] = 64'hDEAD_BEEF_0000_0000 | DATA_W'(j);
    end
    $display("[TB] start");
    test_reset();
    test_init_sweep(0);
    test_init_idle();
    test_round_robin();
    test_same_addr();
    test_only_b();
    test_addr_zero();
    test_reset_mid_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
